// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one pipelined 18x18 multiplier
// Issues at most one multiply per cycle and routes each product back to its issuer.
module mult_arbiter #(
   parameter int  NREQ = 4,
   parameter int  LAT  = 2,
   localparam int IDXW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*18-1:0] req_a,
   input  logic [NREQ*18-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [35:0]        rsp_p,
   output logic               mul_en,
   output logic [17:0]        mul_a,
   output logic [17:0]        mul_b,
   input  logic [35:0]        mul_p,
   output logic               busy
);

   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] gnt_idx;
   logic [IDXW:0]   cand;
   logic            issue;
   logic [LAT-1:0]  vld_q, vld_d;
   logic [IDXW-1:0] idx_q [LAT];
   logic [IDXW-1:0] idx_d [LAT];

   // Search upward from the pointer; cand is one bit wider so ptr+k never overflows.
   always_comb begin
      issue   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(NREQ)) begin
            cand = cand - (IDXW+1)'(NREQ);
         end
         if (!issue && !rst && req_valid[cand[IDXW-1:0]]) begin
            issue   = 1'b1;
            gnt_idx = cand[IDXW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (issue) begin
         req_ready[gnt_idx] = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            mul_a = req_a[18*i +: 18];
            mul_b = req_b[18*i +: 18];
         end
      end
   end

   assign mul_en = issue;

   always_comb begin
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Tracking pipe mirrors the multiplier latency; stage LAT-1 lines up with mul_p.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = issue;
      idx_d[0] = gnt_idx;
      for (int s = 1; s < LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         idx_d[s] = idx_q[s-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         vld_q <= '0;
         for (int s = 0; s < LAT; s++) begin
            idx_q[s] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         vld_q <= vld_d;
         for (int s = 0; s < LAT; s++) begin
            idx_q[s] <= idx_d[s];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_p     = '0;
      if (vld_q[LAT-1]) begin
         rsp_valid[idx_q[LAT-1]] = 1'b1;
         rsp_p                   = mul_p;
      end
   end

   assign busy = |vld_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
// Includes a behavioural two-stage en-gated multiplier standing in for mult18x18.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*18-1:0] req_a;
   logic [NREQ*18-1:0] req_b;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [35:0]        rsp_p;
   logic               mul_en;
   logic [17:0]        mul_a;
   logic [17:0]        mul_b;
   logic [35:0]        mul_p;
   logic               busy;

   logic [17:0] ma_q = '0;
   logic [17:0] mb_q = '0;
   logic [35:0] mp_q = '0;

   int n_checks = 0;
   int n_errors = 0;

   mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_p(rsp_p),
      .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Multiplier model: input registers gated by en, then an output register.
   always_ff @(posedge clk) begin
      if (mul_en) begin
         ma_q <= mul_a;
         mb_q <= mul_b;
      end
      mp_q <= 36'(ma_q) * 36'(mb_q);
   end
   assign mul_p = mp_q;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b);
      req_a[18*i +: 18] = a;
      req_b[18*i +: 18] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [3:0]  t6_req [8];
   logic [3:0]  t6_rsp [8];
   logic [35:0] t6_p   [8];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, 18'(i + 1), 18'd10);
      req_valid = 4'hF;
      #3;
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_mul_en", mul_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'h0);
      req_valid = '0;
      tick();
      rst = 1'b0;
      tick();

      // Test 1: single request, LAT-cycle response
      set_op(0, 18'd3, 18'd5);
      req_valid = 4'b0001;
      #1;
      chk("t1_ready", req_ready, 4'b0001);
      chk("t1_mul_en", mul_en, 1'b1);
      chk("t1_mul_a", mul_a, 18'd3);
      chk("t1_mul_b", mul_b, 18'd5);
      tick();
      req_valid = '0;
      #1;
      chk("t1_busy_mid", busy, 1'b1);
      chk("t1_no_rsp_early", rsp_valid, 4'h0);
      chk("t1_idle_mul_a", mul_a, 18'd0);
      tick();
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_rsp_p", rsp_p, 36'd15);
      chk("t1_busy_rsp", busy, 1'b1);
      tick();
      chk("t1_busy_done", busy, 1'b0);
      chk("t1_rsp_done", rsp_valid, 4'h0);
      chk("t1_rsp_p_zero", rsp_p, 36'd0);

      // Test 2: all requesters continuously valid
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 18'(i + 1), 18'd10);
      for (int k = 0; k < 7; k++) begin
         req_valid = (k < 5) ? 4'hF : 4'h0;
         #1;
         if (k < 5) chk("t2_gnt", req_ready, 4'b0001 << (k % 4));
         if (k >= 2) begin
            chk("t2_rsp_valid", rsp_valid, 4'b0001 << ((k - 2) % 4));
            chk("t2_rsp_p", rsp_p, 36'(((k - 2) % 4 + 1) * 10));
         end
         tick();
      end
      chk("t2_drained", busy, 1'b0);

      // Test 3: maximum operands (pointer now at 1)
      set_op(1, 18'h3FFFF, 18'h3FFFF);
      req_valid = 4'b0010;
      #1;
      chk("t3_gnt", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      tick();
      chk("t3_rsp_valid", rsp_valid, 4'b0010);
      chk("t3_rsp_p", rsp_p, 36'hFFFF80001);
      tick();

      // Test 4: pointer wrap (pointer at 2)
      req_valid = 4'b1000;
      #1;
      chk("t4_gnt3", req_ready, 4'b1000);
      tick();
      req_valid = 4'b1010;
      #1;
      chk("t4_gnt1", req_ready, 4'b0010);
      tick();
      #1;
      chk("t4_gnt3b", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();

      // Test 5: reset with two ops in flight
      set_op(0, 18'd11, 18'd11);
      set_op(1, 18'd12, 18'd12);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      #1;
      chk("t5_pre_rsp", rsp_valid, 4'b0001);
      rst = 1'b1;
      #1;
      chk("t5_rst_rsp_valid", rsp_valid, 4'h0);
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_rsp_p", rsp_p, 36'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t5_no_stale_rsp", rsp_valid, 4'h0);
         tick();
      end
      set_op(2, 18'd7, 18'd6);
      req_valid = 4'b0100;
      #1;
      chk("t5_new_gnt", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      chk("t5_new_early", rsp_valid, 4'h0);
      tick();
      chk("t5_new_rsp_valid", rsp_valid, 4'b0100);
      chk("t5_new_rsp_p", rsp_p, 36'd42);
      tick();
      tick();

      // Test 6: idle gaps, issues in cycles 0, 3, 4 (pointer at 3)
      set_op(0, 18'd2, 18'd9);
      set_op(1, 18'd4, 18'd4);
      set_op(2, 18'd100, 18'd3);
      for (int c = 0; c < 8; c++) begin
         t6_req[c] = 4'h0;
         t6_rsp[c] = 4'h0;
         t6_p[c]   = 36'd0;
      end
      t6_req[0] = 4'b0001;
      t6_req[3] = 4'b0010;
      t6_req[4] = 4'b0100;
      t6_rsp[2] = 4'b0001;  t6_p[2] = 36'd18;
      t6_rsp[5] = 4'b0010;  t6_p[5] = 36'd16;
      t6_rsp[6] = 4'b0100;  t6_p[6] = 36'd300;
      for (int c = 0; c < 8; c++) begin
         req_valid = t6_req[c];
         #1;
         chk("t6_mul_en", mul_en, (t6_req[c] != 4'h0));
         chk("t6_rsp_valid", rsp_valid, t6_rsp[c]);
         chk("t6_rsp_p", rsp_p, t6_p[c]);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
